// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: instruction-side and immediate-side valid/ready channels.
// master drives instructions and consumes immediates; slave is the generator.
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [2:0]      in_fmt;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic            out_fmt_err;

  modport master (
    output in_valid, in_inst, in_fmt, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt_err
  );

  modport slave (
    input  in_valid, in_inst, in_fmt, out_ready,
    output in_ready, out_valid, out_imm, out_fmt_err
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator (I/S/B/U/J) with a 2-entry skid buffer and error counter.
// Optional: define IMM_AUTO_DECODE_EN to derive the format from the opcode instead of in_fmt.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  imm_gen_pipe_if.slave    bus,
  input  logic             flush,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    FMT_I   = 3'd0,
    FMT_S   = 3'd1,
    FMT_B   = 3'd2,
    FMT_U   = 3'd3,
    FMT_J   = 3'd4,
    FMT_ILL = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic            err;
  } entry_t;

  fmt_e        fmt;
  logic [31:0] imm32;
  logic [31:0] inst;
  entry_t      dec;

  entry_t          out_q;
  entry_t          skid_q;
  logic            out_v;
  logic            skid_v;
  logic            rdy_q;
  logic [CNT_W-1:0] cnt_q;

  logic in_ready;
  logic accept;
  logic out_load;
  logic skid_full_next;

  assign inst = bus.in_inst;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    fmt = FMT_ILL;
`ifdef IMM_AUTO_DECODE_EN
    case (inst[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: fmt = FMT_I;
      7'b0100011:                                     fmt = FMT_S;
      7'b1100011:                                     fmt = FMT_B;
      7'b0110111, 7'b0010111:                         fmt = FMT_U;
      7'b1101111:                                     fmt = FMT_J;
      default:                                        fmt = FMT_ILL;
    endcase
`else
    case (bus.in_fmt)
      3'b000:  fmt = FMT_I;
      3'b001:  fmt = FMT_S;
      3'b010:  fmt = FMT_B;
      3'b011:  fmt = FMT_U;
      3'b100:  fmt = FMT_J;
      default: fmt = FMT_ILL;
    endcase
`endif
  end

  // Every format is first built as a 32-bit signed value, then widened once to XLEN.
  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm32 = {inst[31:12], 12'b0};
      FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  always_comb begin
    dec.imm = XLEN'($signed(imm32));
    dec.err = (fmt == FMT_ILL);
  end

  // Flush masks in_ready combinationally so nothing is taken in the flush cycle.
  assign in_ready = rdy_q & ~flush;
  assign accept   = bus.in_valid & in_ready;
  assign out_load = ~out_v | bus.out_ready;

  // Skid holds an entry after the edge if it keeps its old one or catches a stalled accept.
  assign skid_full_next = ~out_load & (skid_v | accept);

  // NOTE: sequential state uses <= so every register samples pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b0;
      out_q  <= '0;
      skid_q <= '0;
    end else if (flush) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b1;
    end else begin
      rdy_q <= ~skid_full_next;
      if (out_load) begin
        if (skid_v) begin
          out_q  <= skid_q;
          out_v  <= 1'b1;
          skid_v <= 1'b0;
        end else if (accept) begin
          out_q <= dec;
          out_v <= 1'b1;
        end else begin
          out_v <= 1'b0;
        end
      end else if (accept) begin
        skid_q <= dec;
        skid_v <= 1'b1;
      end
    end
  end

  // Clear wins over increment; the count saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (err_clr) begin
      cnt_q <= '0;
    end else if (accept && dec.err && !(&cnt_q)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_v;
  assign bus.out_imm     = out_q.imm;
  assign bus.out_fmt_err = out_q.err;
  assign err_cnt         = cnt_q;

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the RISC-V core. Extracts and sign-extends the immediate for all base formats (I, S, B, U, J) to XLEN bits. Output is registered behind a valid/ready handshake with a 2-entry skid buffer, so it can sit between the fetch/decode and execute stages of the pipelined datapath. Also provides a flush input and a saturating illegal-format counter.

Parameters:
XLEN, 32, output immediate width; legal values 32 or 64.
CNT_W, 8, width of the illegal-format error counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  instruction word present.
in_ready  output  1  block can accept; registered, equals ~skid_valid & ~flush.
in_inst  input  32  instruction word.
in_fmt  input  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J; 101-111 illegal.
flush  input  1  synchronous pipeline flush.
out_valid  output  1  out_imm is valid.
out_ready  input  1  consumer accepts.
out_imm  output  XLEN  sign-extended immediate.
out_fmt_err  output  1  entry was decoded with an illegal format.
err_clr  input  1  synchronous clear of err_cnt.
err_cnt  output  CNT_W  count of accepted illegal-format entries.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, skid_valid=0, out_imm=0, out_fmt_err=0, err_cnt=0, in_ready=0. in_ready rises on the first clock after release.
- Accept: occurs when in_valid & in_ready. Latency is 1 cycle: the decoded entry appears on out_* on the next edge if the output register is free or draining. Otherwise it goes to the skid register.
- Immediate extraction (bit 0 of the unextended field listed last):
  - I: inst[31:20]
  - S: inst[31:25], inst[11:7]
  - B: inst[31], inst[7], inst[30:25], inst[11:8], 0
  - U: inst[31:12], 12'b0
  - J: inst[31], inst[19:12], inst[20], inst[30:21], 0
  - All formats are sign-extended from inst[31] to XLEN, including U when XLEN=64.
  - Illegal format: out_imm=0, out_fmt_err=1.
- Output register: loads when (~out_valid | out_ready). Source is the skid entry if skid_valid, else the accepted input. If neither is present, out_valid clears when the current entry is taken.
- Skid register: loads an accepted input when out_valid & ~out_ready. Empties when it transfers to the output register. in_ready is low while it is full.
- Ordering: strictly FIFO. No entry is dropped or duplicated under any out_ready pattern. Full throughput (1 per cycle) when out_ready is held high.
- Simultaneous events:
  - Accept with output drain and skid empty: the new entry goes directly to the output.
  - Accept with skid full: impossible, since in_ready=0.
- Flush (sync): next edge gives out_valid=0, skid_valid=0. in_ready=0 during the flush cycle, so nothing is accepted. err_cnt is unaffected.
- err_cnt:
  - +1 on each accepted illegal-format entry, saturating at 2^CNT_W-1.
  - err_clr has priority over increment and sets the counter to 0.
  - Flushed entries that were already accepted remain counted.
- Reset mid-operation: all buffered entries are discarded immediately (asynchronous).

Optional Feature:
IMM_AUTO_DECODE_EN
- Defined: in_fmt is ignored and the format is derived from in_inst[6:0]:
  - 0000011/0010011/1100111/1110011 -> I
  - 0100011 -> S
  - 1100011 -> B
  - 0110111/0010111 -> U
  - 1101111 -> J
  - any other opcode -> illegal, with out_imm=0, out_fmt_err=1, and err_cnt counting it.
- Not defined: the format comes solely from in_fmt. The in_fmt port exists in both builds.

Test Plan:
1. Type I/U: in_inst=0xFFF00093 with fmt I -> out_imm=0xFFFFFFFF one cycle later. in_inst=0x123450B7 with fmt U -> 0x12345000. With XLEN=64: 0xFFFFFFFFFFFFFFFF and 0x0000000012345000.
2. Type S/J: 0xFE512E23 with fmt S -> 0xFFFFFFFC. 0x0080006F with fmt J -> 0x00000008. 0xFE000EE3 with fmt B -> 0xFFFFFFFC.
3. Backpressure: out_ready=0, present 3 back-to-back entries -> first two accepted, in_ready=0 from cycle 2. Raise out_ready -> entries emerge in order, one per cycle, third accepted after the skid drains.
4. Illegal/counter: fmt=3'b111 -> out_imm=0, out_fmt_err=1, err_cnt=1. With CNT_W=2, 5 illegal entries -> err_cnt=3. err_clr together with an illegal accept -> err_cnt=0.
5. Flush with both registers full and out_ready=0 -> next cycle out_valid=0, in_ready=1. An in_valid presented in the flush cycle is not accepted.
6. Assert rst_n=0 mid-stream -> out_valid=0, err_cnt=0 asynchronously, before the next clock edge. With IMM_AUTO_DECODE_EN defined: 0x0080006F with in_fmt=000 -> out_imm=8 (J).
